if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch front end. It owns the PC, issues requests to the instruction cache over a req/ack handshake, and produces the addedPC/inst pair that the IF/ID pipeline register captures. It applies hazard stalls, branch/jump redirects and cache-miss stalls at the producing end. It also generates the cache-stall signal that freezes the downstream pipeline registers.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  asynchronous, active-high reset
hazard_stall_i  input  1  load-use stall from hazard unit; hold PC
branch_i  input  1  taken branch resolved in ID; redirect to branch_target_i
branch_target_i  input  32  branch target address
jump_i  input  1  jump in ID; redirect to jump_target_i
jump_target_i  input  32  jump target address
icache_ack_i  input  1  cache returns icache_data_i this cycle
icache_data_i  input  32  instruction word
icache_req_o  output  1  fetch request
icache_addr_o  output  32  fetch address (= PC)
addedPC_o  output  32  PC+PC_STEP of the delivered instruction
inst_o  output  32  delivered instruction, 0 (NOP) when not valid
inst_valid_o  output  1  inst_o/addedPC_o carry a real fetch
cache_stall_o  output  1  fetch outstanding; downstream pipeline must hold

Behaviour:
- Reset (async, rst_i=1): pc=RESET_PC, state=FETCH, pending redirect cleared. While reset is asserted: icache_req_o=0, inst_valid_o=0, inst_o=0, addedPC_o=0, cache_stall_o=0. Reset mid-miss abandons the request. A late ack after reset is accepted as the response to the new RESET_PC request only if it arrives while that request is asserted.
- States: FETCH, WAIT, DISCARD.
- FETCH: icache_req_o=1, icache_addr_o=pc.
  - ack same cycle (hit): inst_o=icache_data_i, addedPC_o=pc+PC_STEP, inst_valid_o=1, cache_stall_o=0.
  - no ack: cache_stall_o=1, inst_valid_o=0, next state=WAIT.
- WAIT: icache_req_o=1, address held stable until ack (handshake rule: req/addr never change while unacked). cache_stall_o=1 until the ack cycle. On ack, deliver as in a FETCH hit and return to FETCH.
- DISCARD: entered when a redirect arrives in WAIT. Keep req/addr stable with the old PC and cache_stall_o=1. On ack, drop the data (inst_valid_o=0, inst_o=0) and return to FETCH with pc already equal to the stored target.
- PC update at posedge, in priority order:
  1. branch_i (target from branch_target_i)
  2. jump_i (target from jump_target_i)
  3. hazard_stall_i (hold)
  4. delivered instruction (pc+PC_STEP)
  5. otherwise hold
- Redirect beats hazard_stall_i, because a redirect flushes the stalled instruction.
- Targets have bits[1:0] forced to 0.
- A redirect while in WAIT/DISCARD latches the target into pc immediately but does not change icache_addr_o, which is driven from a separate held request-address register.
- Under hazard_stall_i with a hit, outputs repeat the same instruction each cycle (idempotent re-fetch).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Outputs are combinational from state, the request-address register and ack/data. Latency: 0 cycles on hit, N cycles for an N-cycle miss.

Decomposition:
- Shared package `fetch_pkg`: state enum (FETCH/WAIT/DISCARD), NOP_INST=32'h0, RESET_PC default, PC_STEP.
- One natural sub-module, `fetch_pc_reg`: the PC register with async reset, load (redirect), increment and hold controls, plus target alignment.

Test Plan:
- Reset release, ack tied 1, data=32'h2002_0005 → addr sequence 0,4,8; addedPC_o 4,8,12; inst_valid_o=1 every cycle; cache_stall_o=0.
- Miss: ack delayed 3 cycles at pc=8 → cache_stall_o=1 for 3 cycles, addr stays 8; on ack inst_valid_o=1, addedPC_o=12, next addr 12.
- Redirect during miss: WAIT at pc=16, branch_i=1 with target 32'h40 in cycle 2, ack in cycle 4 → cycle-4 data dropped (inst_valid_o=0); next request addr=32'h40.
- hazard_stall_i=1 for 2 cycles at pc=20 with hits → addr 20 three times, then 24; branch_i with hazard_stall_i both 1 → next addr = target.
- Wrap: RESET_PC=32'hFFFF_FFFC, hits → addr FFFF_FFFC then 0; addedPC_o=0 on first delivery.
- Async reset asserted mid-miss (WAIT, pc=28) → outputs zero immediately without a clock edge; after release, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} fetch_state_e;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    function automatic logic [31:0] align_target(input logic [31:0] t);
        return t & ~32'h3;
    endfunction
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with async reset; redirect load beats increment, else hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] target_i,
    input  logic        inc_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_q, pc_d;

    always_comb pc_d = load_i ? align_target(target_i) : inc_i ? pc_q + 32'(PC_STEP) : pc_q;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) pc_q <= RESET_PC;
        else       pc_q <= pc_d;

    assign pc_o = pc_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, runs the icache req/ack handshake and delivers addedPC/inst to IF/ID.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hazard_stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        icache_ack_i,
    input  logic [31:0] icache_data_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    output logic [31:0] addedPC_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        cache_stall_o
);
    fetch_state_e state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  pc, addr;
    logic         redirect, deliver;

    assign redirect = branch_i | jump_i;

    fetch_pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (redirect),
        .target_i(branch_i ? branch_target_i : jump_target_i),
        .inc_i   (deliver && !hazard_stall_i),
        .pc_o    (pc)
    );

    // Outstanding requests keep their original address even after pc is redirected.
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q    <= FETCH;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end

    always_comb begin
        state_d    = icache_ack_i ? FETCH : (redirect || state_q == DISCARD) ? DISCARD : WAIT;
        req_addr_d = (state_q == FETCH) ? pc : req_addr_q;
    end

    always_comb begin
        addr          = (state_q == FETCH) ? pc : req_addr_q;
        deliver       = !rst_i && icache_ack_i && state_q != DISCARD;
        icache_req_o  = !rst_i;
        icache_addr_o = addr;
        inst_valid_o  = deliver;
        inst_o        = deliver ? icache_data_i : NOP_INST;
        addedPC_o     = deliver ? addr + 32'(PC_STEP) : 32'h0;
        cache_stall_o = !rst_i && !icache_ack_i;
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a queue scoreboard checked on every acked request.
module tb_if_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        hazard = 1'b0, branch = 1'b0, jump = 1'b0, ack = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0, data = '0;
    logic        req, valid, stall;
    logic [31:0] addr, added, inst;
    logic        w_req, w_valid, w_stall;
    logic [31:0] w_addr, w_added, w_inst;
    int          errors = 0, checks = 0, wcyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] added;
        logic [31:0] inst;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk_i(clk), .rst_i(rst), .hazard_stall_i(hazard),
        .branch_i(branch), .branch_target_i(branch_target),
        .jump_i(jump), .jump_target_i(jump_target),
        .icache_ack_i(ack), .icache_data_i(data),
        .icache_req_o(req), .icache_addr_o(addr), .addedPC_o(added),
        .inst_o(inst), .inst_valid_o(valid), .cache_stall_o(stall)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk), .rst_i(rst), .hazard_stall_i(1'b0),
        .branch_i(1'b0), .branch_target_i(32'h0),
        .jump_i(1'b0), .jump_target_i(32'h0),
        .icache_ack_i(1'b1), .icache_data_i(32'h2002_0005),
        .icache_req_o(w_req), .icache_addr_o(w_addr), .addedPC_o(w_added),
        .inst_o(w_inst), .inst_valid_o(w_valid), .cache_stall_o(w_stall)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
        end
    endtask

    // Scoreboard monitor: every acked request consumes one expected response.
    always @(negedge clk)
        if (!rst && req && ack) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got ack at addr %h expected none", addr);
            end else begin
                e = q.pop_front();
                chk("sb_addr", addr, e.addr);
                chk("sb_valid", {31'b0, valid}, {31'b0, e.valid});
                chk("sb_addedPC", added, e.added);
                chk("sb_inst", inst, e.inst);
            end
        end

    // Wrap instance: RESET_PC=FFFF_FFFC with ack tied high.
    always @(negedge clk)
        if (!rst && wcyc < 2) begin
            chk("wrap_addr", w_addr, wcyc == 0 ? 32'hFFFF_FFFC : 32'h0);
            chk("wrap_added", w_added, wcyc == 0 ? 32'h0 : 32'h4);
            chk("wrap_valid", {31'b0, w_valid}, 32'h1);
            wcyc++;
        end

    task automatic cyc(input logic a, input logic hz, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input logic [31:0] ea, input logic ev);
        logic [31:0] d;
        d = ea ^ 32'h2002_0005;
        ack = a; data = d; hazard = hz; branch = br; branch_target = bt; jump = jp; jump_target = jt;
        if (a) q.push_back('{ea, ev, ev ? ea + 32'd4 : 32'd0, ev ? d : 32'd0});
        @(negedge clk);
        chk("req_addr", addr, ea);
        chk("cache_stall", {31'b0, stall}, {31'b0, !a});
        if (!a) chk("valid_on_miss", {31'b0, valid}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'b0, req}, 32'h0);
        chk({tag, "_valid"}, {31'b0, valid}, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_added"}, added, 32'h0);
        chk({tag, "_stall"}, {31'b0, stall}, 32'h0);
    endtask

    initial begin
        ack = 1'b1; data = 32'h2002_0005;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_wrap_req", {31'b0, w_req}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        // hits then a 3-cycle miss at 8
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 1);
        cyc(1, 0, 0, 0, 0, 0, 32'h4, 1);
        cyc(0, 0, 0, 0, 0, 0, 32'h8, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h8, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h8, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h8, 1);
        cyc(1, 0, 0, 0, 0, 0, 32'hC, 1);
        // branch during miss: old address held, data dropped
        cyc(0, 0, 0, 0, 0, 0, 32'h10, 0);
        cyc(0, 0, 1, 32'h40, 0, 0, 32'h10, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h10, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h10, 0);
        cyc(1, 0, 0, 0, 0, 0, 32'h40, 1);
        // unaligned branch target to 0x14, then hazard stall
        cyc(1, 0, 1, 32'h17, 0, 0, 32'h44, 1);
        cyc(1, 1, 0, 0, 0, 0, 32'h14, 1);
        cyc(1, 1, 0, 0, 0, 0, 32'h14, 1);
        cyc(1, 0, 0, 0, 0, 0, 32'h14, 1);
        cyc(1, 0, 0, 0, 0, 0, 32'h18, 1);
        cyc(1, 1, 1, 32'h100, 0, 0, 32'h1C, 1);
        cyc(1, 0, 0, 0, 1, 32'h203, 32'h100, 1);
        cyc(1, 0, 1, 32'h300, 1, 32'h400, 32'h200, 1);
        cyc(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 32'h300, 1);
        cyc(1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1);
        cyc(1, 0, 1, 32'h1C, 0, 0, 32'h0, 1);
        // async reset mid-miss at 0x1C
        cyc(0, 0, 0, 0, 0, 0, 32'h1C, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'h1C, 0);
        ack = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 32'h0, 1);
        cyc(1, 0, 0, 0, 0, 0, 32'h4, 1);
        ack = 1'b0;
        repeat (2) @(posedge clk);
        chk("sb_drained", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
